// File: rtl/mem_tile_addr_generator.sv
// Address generator for one matrix: tiled column-chunk order (A operand) or
// linear row order (B/C), streamed over a valid/ready handshake.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start_i; descriptor latched on start
// S_EMIT | presenting addr_o; advances on each accepted handshake
// S_FIN  | one-cycle done_o pulse after the final handshake
module mem_tile_addr_generator #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DIM_WIDTH        = 16,
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int BUS_WIDTH_BYTES  = 32,
    parameter int TILE_ROWS        = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  mode_i,
    input  logic [DIM_WIDTH-1:0]  m,
    input  logic [DIM_WIDTH-1:0]  n,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_valid_o,
    input  logic                  addr_ready_i,
    output logic                  addr_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int ELEMENTS = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;
    localparam int LOG_DW   = $clog2(DATA_WIDTH_BYTES);
    localparam int LOG_TILE = $clog2(TILE_ROWS);
    // One spare bit so row/column look-ahead sums never overflow.
    localparam int CW       = DIM_WIDTH + 1;

    localparam logic [CW-1:0]         ELEM_C = CW'(ELEMENTS);
    localparam logic [CW-1:0]         TILE_C = CW'(TILE_ROWS);
    localparam logic [CW-1:0]         ONE_C  = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] STEP_C = ADDR_WIDTH'(BUS_WIDTH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_FIN
    } state_t;

    state_t state, state_nxt;

    logic                  mode_q;
    logic [CW-1:0]         m_q, n_q;
    logic [ADDR_WIDTH-1:0] stride_q, tile_stride_q;
    logic [CW-1:0]         row_cnt, blk_row, col_cnt;
    logic [ADDR_WIDTH-1:0] blk_addr, seg_addr;

    logic [CW-1:0]         nxt_row, nxt_blk_row, nxt_col;
    logic [ADDR_WIDTH-1:0] nxt_blk_addr, nxt_seg_addr, nxt_addr;
    logic                  col_more, row_more, nxt_last, last_d;
    logic                  hs, init_last;
    logic [ADDR_WIDTH-1:0] start_stride, start_tile_stride;

    assign hs                = (state == S_EMIT) && addr_ready_i;
    assign init_last         = (m == DIM_WIDTH'(1)) && ({1'b0, n} <= ELEM_C);
    assign start_stride      = ADDR_WIDTH'(n) << LOG_DW;
    assign start_tile_stride = start_stride << LOG_TILE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = (m == '0 || n == '0) ? S_FIN : S_EMIT;
                end
            end
            S_EMIT: begin
                if (abort_i) begin
                    state_nxt = S_IDLE;
                end else if (hs && addr_last_o) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // seg_addr is the address of the current chunk at the block's first row
    // (tiled) or of chunk 0 of the current row (linear).
    always_comb begin
        nxt_row      = row_cnt;
        nxt_blk_row  = blk_row;
        nxt_col      = col_cnt;
        nxt_blk_addr = blk_addr;
        nxt_seg_addr = seg_addr;
        nxt_addr     = addr_o;
        col_more     = (col_cnt + ELEM_C) < n_q;
        row_more     = ((row_cnt + ONE_C) < m_q) && ((row_cnt + ONE_C) < (blk_row + TILE_C));
        if (!mode_q) begin
            if (row_more) begin
                nxt_row  = row_cnt + ONE_C;
                nxt_addr = addr_o + stride_q;
            end else if (col_more) begin
                nxt_col      = col_cnt + ELEM_C;
                nxt_row      = blk_row;
                nxt_seg_addr = seg_addr + STEP_C;
                nxt_addr     = seg_addr + STEP_C;
            end else begin
                nxt_col      = '0;
                nxt_blk_row  = blk_row + TILE_C;
                nxt_row      = blk_row + TILE_C;
                nxt_blk_addr = blk_addr + tile_stride_q;
                nxt_seg_addr = blk_addr + tile_stride_q;
                nxt_addr     = blk_addr + tile_stride_q;
            end
        end else begin
            if (col_more) begin
                nxt_col  = col_cnt + ELEM_C;
                nxt_addr = addr_o + STEP_C;
            end else begin
                nxt_col      = '0;
                nxt_row      = row_cnt + ONE_C;
                nxt_seg_addr = seg_addr + stride_q;
                nxt_addr     = seg_addr + stride_q;
            end
        end
        // The final address in both orders is the last chunk of row m-1.
        nxt_last = ((nxt_row + ONE_C) == m_q) && ((nxt_col + ELEM_C) >= n_q);
    end

    always_comb begin
        last_d = addr_last_o;
        if (state == S_IDLE) begin
            last_d = init_last;
        end else if (hs) begin
            last_d = nxt_last;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_o        <= '0;
            addr_valid_o  <= 1'b0;
            addr_last_o   <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            mode_q        <= 1'b0;
            m_q           <= '0;
            n_q           <= '0;
            stride_q      <= '0;
            tile_stride_q <= '0;
            row_cnt       <= '0;
            blk_row       <= '0;
            col_cnt       <= '0;
            blk_addr      <= '0;
            seg_addr      <= '0;
        end else begin
            addr_valid_o <= (state_nxt == S_EMIT);
            busy_o       <= (state_nxt != S_IDLE);
            done_o       <= (state_nxt == S_FIN);
            addr_last_o  <= last_d && (state_nxt == S_EMIT);
            if (state == S_IDLE && start_i) begin
                mode_q        <= mode_i;
                m_q           <= {1'b0, m};
                n_q           <= {1'b0, n};
                stride_q      <= start_stride;
                tile_stride_q <= start_tile_stride;
                row_cnt       <= '0;
                blk_row       <= '0;
                col_cnt       <= '0;
                blk_addr      <= base_addr;
                seg_addr      <= base_addr;
                addr_o        <= base_addr;
            end else if (hs) begin
                row_cnt  <= nxt_row;
                blk_row  <= nxt_blk_row;
                col_cnt  <= nxt_col;
                blk_addr <= nxt_blk_addr;
                seg_addr <= nxt_seg_addr;
                addr_o   <= nxt_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_tile_addr_generator.sv
// Bench for mem_tile_addr_generator: fixed traversals, backpressure, abort,
// reset and randomized descriptors against a loop-based address model.
module tb_mem_tile_addr_generator;

    localparam int TILE = 2;
    localparam int BUS  = 32;
    localparam int ELEM = 32;

    localparam int P_EMIT = 0;
    localparam int P_FIN  = 1;
    localparam int P_IDLE = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic        abort_i;
    logic        mode_i;
    logic [15:0] m;
    logic [15:0] n;
    logic [15:0] base_addr;
    logic [15:0] addr_o;
    logic        addr_valid_o;
    logic        addr_ready_i;
    logic        addr_last_o;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] seq_tiled[$];

    mem_tile_addr_generator #(
        .ADDR_WIDTH      (16),
        .DIM_WIDTH       (16),
        .DATA_WIDTH_BYTES(1),
        .BUS_WIDTH_BYTES (BUS),
        .TILE_ROWS       (TILE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .mode_i      (mode_i),
        .m           (m),
        .n           (n),
        .base_addr   (base_addr),
        .addr_o      (addr_o),
        .addr_valid_o(addr_valid_o),
        .addr_ready_i(addr_ready_i),
        .addr_last_o (addr_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".addr"},  32'(addr_o),       32'h0);
        check({tag, ".valid"}, 32'(addr_valid_o), 32'h0);
        check({tag, ".last"},  32'(addr_last_o),  32'h0);
        check({tag, ".busy"},  32'(busy_o),       32'h0);
        check({tag, ".done"},  32'(done_o),       32'h0);
    endtask

    // Reference order: plain nested loops over the visiting rules.
    task automatic build_ref(input bit md, input int mm, input int nn, input int base);
        int nch;
        nch = (nn + ELEM - 1) / ELEM;
        exp_q.delete();
        if (md == 1'b0) begin
            for (int r0 = 0; r0 < mm; r0 += TILE)
                for (int ch = 0; ch < nch; ch++)
                    for (int r = r0; r < mm && r < r0 + TILE; r++)
                        exp_q.push_back(16'(base + r * nn + ch * BUS));
        end else begin
            for (int r = 0; r < mm; r++)
                for (int ch = 0; ch < nch; ch++)
                    exp_q.push_back(16'(base + r * nn + ch * BUS));
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; exp_q holds the sequence.
    task automatic run_case(input string name, input bit md, input int mm, input int nn,
                            input int base, input bit rand_ready, input int abort_after,
                            input bit glitch_start);
        int  phase;
        int  hs_count;
        int  cyc;
        bit  rdy;
        bit  abt;
        start_i   = 1'b1;
        mode_i    = md;
        m         = 16'(mm);
        n         = 16'(nn);
        base_addr = 16'(base);
        @(posedge clk); #1;
        start_i   = 1'b0;
        mode_i    = 1'($urandom);
        m         = 16'($urandom);
        n         = 16'($urandom);
        base_addr = 16'($urandom);
        phase     = (exp_q.size() == 0) ? P_FIN : P_EMIT;
        hs_count  = 0;
        cyc       = 0;
        while (phase != P_IDLE && cyc < 500) begin
            check($sformatf("%s.valid@%0d", name, cyc), 32'(addr_valid_o), 32'(phase == P_EMIT));
            check($sformatf("%s.done@%0d", name, cyc),  32'(done_o),       32'(phase == P_FIN));
            check($sformatf("%s.busy@%0d", name, cyc),  32'(busy_o),       32'h1);
            if (phase == P_EMIT) begin
                check($sformatf("%s.addr%0d", name, hs_count), 32'(addr_o), 32'(exp_q[hs_count]));
                check($sformatf("%s.last%0d", name, hs_count), 32'(addr_last_o),
                      32'(hs_count == exp_q.size() - 1));
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            abt = (abort_after >= 0) && (hs_count == abort_after) && (phase == P_EMIT);
            addr_ready_i = rdy;
            abort_i      = abt;
            if (glitch_start && cyc == 0) begin
                start_i   = 1'b1;
                mode_i    = 1'b1;
                m         = 16'd4;
                n         = 16'd64;
                base_addr = 16'h2000;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            abort_i = 1'b0;
            if (abt) begin
                phase = P_IDLE;
            end else if (phase == P_EMIT && rdy) begin
                hs_count++;
                if (hs_count == exp_q.size()) phase = P_FIN;
            end else if (phase == P_FIN) begin
                phase = P_IDLE;
            end
            cyc++;
        end
        if (cyc >= 500) check({name, ".timeout"}, 32'h0, 32'h1);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s.idle_valid%0d", name, k), 32'(addr_valid_o), 32'h0);
            check($sformatf("%s.idle_busy%0d", name, k),  32'(busy_o),       32'h0);
            check($sformatf("%s.idle_done%0d", name, k),  32'(done_o),       32'h0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        mode_i       = 1'b0;
        m            = '0;
        n            = '0;
        base_addr    = '0;
        addr_ready_i = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        seq_tiled = '{16'h100, 16'h140, 16'h120, 16'h160, 16'h180, 16'h1A0};

        exp_q = seq_tiled;
        run_case("tiled", 1'b0, 3, 64, 'h100, 1'b0, -1, 1'b0);

        exp_q = '{16'h100, 16'h120, 16'h140, 16'h160, 16'h180, 16'h1A0};
        run_case("linear", 1'b1, 3, 64, 'h100, 1'b0, -1, 1'b0);

        exp_q = '{16'hFFC0, 16'hFFE0, 16'hFFE8, 16'h0008};
        run_case("wrap", 1'b1, 2, 40, 'hFFC0, 1'b0, -1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            exp_q = seq_tiled;
            run_case($sformatf("bp%0d", i), 1'b0, 3, 64, 'h100, 1'b1, -1, 1'b0);
        end

        exp_q.delete();
        run_case("degen_m0", 1'b0, 0, 64, 'h100, 1'b0, -1, 1'b1);
        exp_q.delete();
        run_case("degen_n0", 1'b1, 5, 0, 'h300, 1'b0, -1, 1'b0);

        exp_q = seq_tiled;
        run_case("abort", 1'b0, 3, 64, 'h100, 1'b0, 3, 1'b0);
        exp_q = seq_tiled;
        run_case("after_abort", 1'b0, 3, 64, 'h100, 1'b0, -1, 1'b0);

        exp_q = seq_tiled;
        run_case("glitch", 1'b0, 3, 64, 'h100, 1'b1, -1, 1'b1);

        start_i      = 1'b1;
        mode_i       = 1'b0;
        m            = 16'd3;
        n            = 16'd64;
        base_addr    = 16'h100;
        addr_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset.valid", 32'(addr_valid_o), 32'h0);
        exp_q = seq_tiled;
        run_case("after_reset", 1'b0, 3, 64, 'h100, 1'b0, -1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            bit md;
            int mm;
            int nn;
            int bs;
            md = 1'($urandom_range(0, 1));
            mm = $urandom_range(1, 5);
            nn = $urandom_range(1, 100);
            bs = $urandom_range(0, 65535);
            build_ref(md, mm, nn, bs);
            run_case($sformatf("rand%0d", i), md, mm, nn, bs, 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
